hazard_stall_unit: RTL and testbench

Decode-stage pipeline controller that handles the hazards register forwarding cannot resolve. Three cases are covered:
- load-use dependencies, which need stall cycles and bubbles;
- taken-branch squashes, which need multi-cycle flushes;
- data-memory wait states, which freeze the whole pipeline.

The EX-stage forwarding selector handles every other RAW case. This block sits beside it in Decode, watches ID operands against the EX-stage destination, and drives the PC, IF/ID and ID/EX register controls.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_stall_unit_cmp.sv | 19 +
 rtl/hazard_stall_unit.sv | 163 ++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and parameter-legality helpers for the decode-stage hazard/stall controller.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StLStall = 2'b01,
        StBFlush = 2'b10
    } hazard_state_t;

    function automatic bit load_cycles_legal(input int unsigned n);
        return (n >= 1) && (n <= 3);
    endfunction

    function automatic bit branch_cycles_legal(input int unsigned n);
        return (n >= 1) && (n <= 2);
    endfunction

    function automatic bit cnt_width_legal(input int unsigned w);
        return w >= 1;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_cmp.sv
// Combinational load-use compare: ID operands against the destination of an in-flight load.
module hazard_cmp #(
    parameter int unsigned AddrW = 3
) (
    input  logic [AddrW-1:0] src_i,
    input  logic [AddrW-1:0] dst_i,
    input  logic             src_used_i,
    input  logic             dst_used_i,
    input  logic [AddrW-1:0] ex_dst_i,
    input  logic             ex_mem_read_i,
    output logic             hazard_o
);

    always_comb begin
        hazard_o = ex_mem_read_i &
                   ((src_used_i & (src_i == ex_dst_i)) | (dst_used_i & (dst_i == ex_dst_i)));
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage stall/flush controller for load-use, taken-branch and memory-wait hazards.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZARD_STALL_PERF_CNT_EN is defined.
module hazard_stall_unit #(
    parameter int unsigned REG_ADDR_W          = hazard_pkg::REG_ADDR_W,
    parameter int unsigned LOAD_STALL_CYCLES   = 1,
    parameter int unsigned BRANCH_FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W               = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_src_used,
    input  logic                  id_dst_used,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  pipe_en,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  ifid_flush,
    output logic                  idex_flush,
`ifdef HAZARD_STALL_PERF_CNT_EN
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`else
    output logic [1:0]            state_o
`endif
);

    import hazard_pkg::*;

    if (!load_cycles_legal(LOAD_STALL_CYCLES)) begin : g_bad_load
        $error("LOAD_STALL_CYCLES must be 1..3");
    end
    if (!branch_cycles_legal(BRANCH_FLUSH_CYCLES)) begin : g_bad_branch
        $error("BRANCH_FLUSH_CYCLES must be 1..2");
    end
    if (!cnt_width_legal(CNT_W)) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    hazard_state_t state_q, state_d;
    logic [1:0]    rem_q, rem_d;
    logic          hazard;
    logic          branch_accept;

    hazard_cmp #(
        .AddrW (REG_ADDR_W)
    ) u_cmp (
        .src_i         (id_src),
        .dst_i         (id_dst),
        .src_used_i    (id_src_used),
        .dst_used_i    (id_dst_used),
        .ex_dst_i      (ex_dst),
        .ex_mem_read_i (ex_mem_read),
        .hazard_o      (hazard)
    );

    always_comb begin
        pipe_en       = 1'b0;
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        idex_bubble   = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        branch_accept = 1'b0;
        state_d       = state_q;
        rem_d         = rem_q;

        // Reset forces all controls low; a memory wait freezes state and rem in place.
        if (!rst && !mem_busy) begin
            unique case (state_q)
                StRun: begin
                    pipe_en = 1'b1;
                    if (ex_branch_taken) begin
                        pc_write      = 1'b1;
                        ifid_flush    = 1'b1;
                        idex_flush    = 1'b1;
                        branch_accept = 1'b1;
                        if (BRANCH_FLUSH_CYCLES == 2) begin
                            state_d = StBFlush;
                            rem_d   = 2'd1;
                        end
                    end else if (hazard) begin
                        idex_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = StLStall;
                            rem_d   = 2'(LOAD_STALL_CYCLES - 1);
                        end
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                StLStall: begin
                    pipe_en     = 1'b1;
                    idex_bubble = 1'b1;
                    rem_d       = rem_q - 2'd1;
                    if (rem_q <= 2'd1) begin
                        state_d = StRun;
                    end
                end
                StBFlush: begin
                    pipe_en    = 1'b1;
                    pc_write   = 1'b1;
                    ifid_flush = 1'b1;
                    rem_d      = rem_q - 2'd1;
                    state_d    = StRun;
                end
                default: begin
                    state_d = StRun;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (idex_bubble && pipe_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_accept && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: driver queues hand-computed expectations, monitor checks.
module tb_hazard_stall_unit;

    localparam logic [5:0] NORM  = 6'b111000; // {pipe_en,pc_write,ifid_write,bubble,ifid_fl,idex_fl}
    localparam logic [5:0] STALL = 6'b100100;
    localparam logic [5:0] BR    = 6'b110011;
    localparam logic [5:0] BF    = 6'b110010;
    localparam logic [5:0] FRZ   = 6'b000000;

    typedef struct {
        logic [7:0] outs;
        logic [3:0] sc;
        logic [3:0] fc;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] id_src = '0, id_dst = '0, ex_dst = '0;
    logic       id_src_used = 1'b0, id_dst_used = 1'b0;
    logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;
    logic       pipe_en, pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush;
    logic [1:0] state_o;
    logic [3:0] stall_cnt, flush_cnt;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [3:0] sc = '0;
    logic [3:0] fc = '0;

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .REG_ADDR_W          (3),
        .LOAD_STALL_CYCLES   (2),
        .BRANCH_FLUSH_CYCLES (2),
        .CNT_W               (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_src          (id_src),
        .id_dst          (id_dst),
        .id_src_used     (id_src_used),
        .id_dst_used     (id_dst_used),
        .ex_dst          (ex_dst),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pipe_en         (pipe_en),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_bubble     (idex_bubble),
        .ifid_flush      (ifid_flush),
`ifdef HAZARD_STALL_PERF_CNT_EN
        .idex_flush      (idex_flush),
        .state_o         (state_o),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`else
        .idex_flush      (idex_flush),
        .state_o         (state_o)
`endif
    );

`ifndef HAZARD_STALL_PERF_CNT_EN
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    // Monitor: every negedge with a pending expectation is one observed output cycle.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = {pipe_en, pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
                       state_o};
                n_cmp++;
                if (act !== e.outs) begin
                    n_bad++;
                    $display("FAIL %s: outputs got %b want %b", e.name, act, e.outs);
                end
`ifdef HAZARD_STALL_PERF_CNT_EN
                n_cmp++;
                if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    n_bad++;
                    $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                             e.name, stall_cnt, flush_cnt, e.sc, e.fc);
                end
`endif
            end
        end
    end

    task automatic step(input logic r, input logic [2:0] s, input logic su, input logic [2:0] d,
                        input logic du, input logic [2:0] ed, input logic mr, input logic bt,
                        input logic bz, input logic [5:0] o, input logic [1:0] st,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_src = s; id_src_used = su; id_dst = d; id_dst_used = du;
        ex_dst = ed; ex_mem_read = mr; ex_branch_taken = bt; mem_busy = bz;
        e.outs = {o, st};
        e.sc   = sc;
        e.fc   = fc;
        e.name = nm;
        q.push_back(e);
    endtask

    // Operand r3 read in ID, EX writes r3; mr selects whether EX is a load.
    task automatic cyc(input logic mr, input logic bt, input logic bz, input logic [5:0] o,
                       input logic [1:0] st, input string nm);
        step(1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, mr, bt, bz, o, st, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        step(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, FRZ, 2'b00, "reset");
        cyc(1'b0, 1'b0, 1'b0, NORM, 2'b00, "normal");

        cyc(1'b1, 1'b0, 1'b0, STALL, 2'b00, "lu_stall1");  sc = sc + 1;
        cyc(1'b0, 1'b0, 1'b0, STALL, 2'b01, "lu_stall2");  sc = sc + 1;
        cyc(1'b0, 1'b0, 1'b0, NORM,  2'b00, "lu_done");

        step(1'b0, 3'd3, 1'b0, 3'd3, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, NORM, 2'b00, "unused_ops");

        step(1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, STALL, 2'b00, "dst_stall1");
        sc = sc + 1;
        cyc(1'b0, 1'b0, 1'b0, STALL, 2'b01, "dst_stall2");  sc = sc + 1;
        cyc(1'b0, 1'b0, 1'b0, NORM,  2'b00, "dst_done");

        cyc(1'b1, 1'b1, 1'b0, BR,   2'b00, "br_beats_hz");  fc = fc + 1;
        cyc(1'b0, 1'b0, 1'b0, BF,   2'b10, "br_flush2");
        cyc(1'b0, 1'b0, 1'b0, NORM, 2'b00, "br_done");

        cyc(1'b1, 1'b0, 1'b0, STALL, 2'b00, "frz_stall1"); sc = sc + 1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, FRZ, 2'b01, "frz_held");
        cyc(1'b0, 1'b0, 1'b0, STALL, 2'b01, "frz_resume"); sc = sc + 1;
        cyc(1'b0, 1'b0, 1'b0, NORM,  2'b00, "frz_done");

        cyc(1'b1, 1'b1, 1'b1, FRZ,  2'b00, "frz_run_br");
        cyc(1'b0, 1'b1, 1'b0, BR,   2'b00, "br2");          fc = fc + 1;
        cyc(1'b0, 1'b0, 1'b1, FRZ,  2'b10, "frz_bflush");
        cyc(1'b0, 1'b0, 1'b0, BF,   2'b10, "bflush_resume");
        cyc(1'b0, 1'b0, 1'b0, NORM, 2'b00, "br2_done");

        cyc(1'b1, 1'b0, 1'b0, STALL, 2'b00, "rst_pre");    sc = sc + 1;
        sc = '0;
        fc = '0;
        step(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, FRZ, 2'b00, "rst_mid");
        step(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, FRZ, 2'b00, "rst_hold");
        cyc(1'b0, 1'b0, 1'b0, NORM, 2'b00, "rst_after");

        for (int i = 0; i < 20; i++) begin
            sc = (i > 15) ? 4'd15 : 4'(i);
            cyc(1'b1, 1'b0, 1'b0, STALL, 2'(i % 2), "sat_stall");
        end
        sc = 4'd15;
        cyc(1'b0, 1'b0, 1'b0, NORM, 2'b00, "sat_final");

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
